// File: rtl/i2s_tx_scheduler_if.sv
// rtl/i2s_tx_scheduler_if.sv - source request and transmitter load-port bundle for the I2S sample scheduler
interface i2s_tx_scheduler_if #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 24
);
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_ack;
  logic                      tx_ready;
  logic [DATA_W-1:0]         tx_pcm;
  logic                      tx_sent;

  // scheduler side
  modport master (
    input  src_valid, src_data, tx_ready,
    output src_ack, tx_pcm, tx_sent
  );

  // sources and transmitter side
  modport slave (
    output src_valid, src_data, tx_ready,
    input  src_ack, tx_pcm, tx_sent
  );
endinterface

// File: rtl/i2s_tx_scheduler.sv
// rtl/i2s_tx_scheduler.sv - arbitrates audio sources into one I2S sample per transmitter ready window
module i2s_tx_scheduler #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_W     = 24,
  parameter int UR_TIMEOUT = 64,
  localparam int GW        = $clog2(NUM_SRC),
  localparam int UCW       = $clog2(UR_TIMEOUT)
) (
  input  logic               clk,
  input  logic               rstn,
  i2s_tx_scheduler_if.master bus,
  input  logic [NUM_SRC-1:0] cfg_enable,
  input  logic               cfg_rr,
  input  logic               cfg_mute,
  input  logic               cfg_hold_last,
  output logic [GW-1:0]      grant_id,
  output logic               fill_flag,
  output logic [15:0]        underrun_cnt
);

  typedef enum logic {IDLE, WAIT_DROP} state_t;

  localparam logic [UCW-1:0] UC_LAST = UCW'(UR_TIMEOUT - 1);

  state_t               state, state_nxt;
  logic [UCW-1:0]       uc, uc_nxt;
  logic [GW-1:0]        rr_ptr, rr_nxt;
  logic [DATA_W-1:0]    pcm_q, pcm_nxt;
  logic                 sent_q, sent_nxt;
  logic [NUM_SRC-1:0]   ack_q, ack_nxt;
  logic [GW-1:0]        gid_nxt;
  logic                 fill_nxt;
  logic [15:0]          ucnt_nxt;

  logic [NUM_SRC-1:0]   eligible;
  logic                 any_elig;
  logic                 found;
  logic [GW-1:0]        cand;
  logic [GW-1:0]        win;
  logic [DATA_W-1:0]    src_arr [NUM_SRC];

  // unpack the flat source data bus into one word per source
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_arr[i] = bus.src_data[i*DATA_W +: DATA_W];
    end
  end

  // pick the winner: round-robin starting after the last real grant, or lowest index
  always_comb begin
    eligible = bus.src_valid & cfg_enable;
    any_elig = |eligible;
    win      = '0;
    found    = 1'b0;
    cand     = '0;
    if (cfg_rr) begin
      for (int k = 1; k <= NUM_SRC; k++) begin
        cand = GW'((int'(rr_ptr) + k) % NUM_SRC);
        if (!found && eligible[cand]) begin
          win   = cand;
          found = 1'b1;
        end
      end
    end else begin
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
        if (eligible[i]) win = GW'(i);
      end
    end
  end

  // next state and next output values; strobes default low so they last one cycle
  always_comb begin
    state_nxt = state;
    uc_nxt    = uc;
    rr_nxt    = rr_ptr;
    pcm_nxt   = pcm_q;
    sent_nxt  = 1'b0;
    ack_nxt   = '0;
    gid_nxt   = grant_id;
    fill_nxt  = fill_flag;
    ucnt_nxt  = underrun_cnt;
    case (state)
      IDLE: begin
        if (!bus.tx_ready) begin
          uc_nxt = '0;
        end else if (any_elig) begin
          pcm_nxt      = cfg_mute ? '0 : src_arr[win];
          sent_nxt     = 1'b1;
          ack_nxt[win] = 1'b1;
          gid_nxt      = win;
          fill_nxt     = 1'b0;
          rr_nxt       = win;
          uc_nxt       = '0;
          state_nxt    = WAIT_DROP;
        end else if (uc == UC_LAST) begin
          // fill sample: muting wins over holding the previous value
          pcm_nxt   = (cfg_hold_last && !cfg_mute) ? pcm_q : '0;
          sent_nxt  = 1'b1;
          fill_nxt  = 1'b1;
          ucnt_nxt  = (underrun_cnt == 16'hFFFF) ? underrun_cnt : underrun_cnt + 16'd1;
          uc_nxt    = '0;
          state_nxt = WAIT_DROP;
        end else begin
          uc_nxt = uc + UCW'(1);
        end
      end
      WAIT_DROP: begin
        // no arbitration until the transmitter drops ready: one sample per window
        uc_nxt = '0;
        if (!bus.tx_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // register state and every output
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      uc           <= '0;
      rr_ptr       <= GW'(NUM_SRC - 1);
      pcm_q        <= '0;
      sent_q       <= 1'b0;
      ack_q        <= '0;
      grant_id     <= '0;
      fill_flag    <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      state        <= state_nxt;
      uc           <= uc_nxt;
      rr_ptr       <= rr_nxt;
      pcm_q        <= pcm_nxt;
      sent_q       <= sent_nxt;
      ack_q        <= ack_nxt;
      grant_id     <= gid_nxt;
      fill_flag    <= fill_nxt;
      underrun_cnt <= ucnt_nxt;
    end
  end

  assign bus.tx_pcm  = pcm_q;
  assign bus.tx_sent = sent_q;
  assign bus.src_ack = ack_q;

endmodule

// File: tb/tb_i2s_tx_scheduler.sv
// tb/tb_i2s_tx_scheduler.sv - randomized and directed self-checking bench for i2s_tx_scheduler
module tb_i2s_tx_scheduler;

  localparam int N   = 4;
  localparam int DW  = 24;
  localparam int URT = 64;

  logic        clk;
  logic        rstn;
  logic [N-1:0] cfg_enable;
  logic        cfg_rr;
  logic        cfg_mute;
  logic        cfg_hold_last;
  logic [1:0]  grant_id;
  logic        fill_flag;
  logic [15:0] underrun_cnt;

  i2s_tx_scheduler_if #(.NUM_SRC(N), .DATA_W(DW)) bus ();

  i2s_tx_scheduler #(.NUM_SRC(N), .DATA_W(DW), .UR_TIMEOUT(URT)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .bus           (bus),
    .cfg_enable    (cfg_enable),
    .cfg_rr        (cfg_rr),
    .cfg_mute      (cfg_mute),
    .cfg_hold_last (cfg_hold_last),
    .grant_id      (grant_id),
    .fill_flag     (fill_flag),
    .underrun_cnt  (underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int strobes  = 0;
  int ack2_cnt = 0;

  logic [DW-1:0] sdata [N];

  // reference model: one delivered sample per ready window, fill after URT dry cycles
  bit            m_wait;
  int            m_dry;
  int            m_rr;
  logic [DW-1:0] e_pcm;
  bit            e_sent;
  logic [N-1:0]  e_ack;
  int            e_gid;
  bit            e_fill;
  int            e_ucnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_src(input int i, input bit v, input logic [DW-1:0] d);
    sdata[i] = d;
    bus.src_valid[i] = v;
    bus.src_data[i*DW +: DW] = d;
  endtask

  task automatic model_reset();
    m_wait = 0; m_dry = 0; m_rr = N - 1;
    e_pcm = '0; e_sent = 0; e_ack = '0; e_gid = 0; e_fill = 0; e_ucnt = 0;
  endtask

  function automatic int pick(input logic [N-1:0] elig);
    if (cfg_rr) begin
      for (int k = 1; k <= N; k++) if (elig[(m_rr + k) % N]) return (m_rr + k) % N;
    end else begin
      for (int i = 0; i < N; i++) if (elig[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_step();
    logic [N-1:0] elig;
    int g;
    elig   = bus.src_valid & cfg_enable;
    e_sent = 0;
    e_ack  = '0;
    if (m_wait) begin
      m_dry = 0;
      if (!bus.tx_ready) m_wait = 0;
    end else if (!bus.tx_ready) begin
      m_dry = 0;
    end else if (elig != '0) begin
      g = pick(elig);
      e_pcm = cfg_mute ? '0 : sdata[g];
      e_sent = 1; e_ack = N'(1) << g; e_gid = g; e_fill = 0;
      m_rr = g; m_wait = 1; m_dry = 0;
    end else if (m_dry == URT - 1) begin
      e_pcm = (cfg_hold_last && !cfg_mute) ? e_pcm : '0;
      e_sent = 1; e_fill = 1;
      if (e_ucnt < 65535) e_ucnt++;
      m_wait = 1; m_dry = 0;
    end else begin
      m_dry++;
    end
  endtask

  // advance one clock and compare every output against the model
  task automatic cycle();
    if (!rstn) model_reset(); else model_step();
    @(posedge clk);
    #1;
    check("tx_pcm", bus.tx_pcm, e_pcm);
    check("tx_sent", bus.tx_sent, e_sent);
    check("src_ack", bus.src_ack, e_ack);
    check("grant_id", grant_id, e_gid);
    check("fill_flag", fill_flag, e_fill);
    check("underrun_cnt", underrun_cnt, e_ucnt);
    if (e_sent) strobes++;
    if (e_ack[2]) ack2_cnt++;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) cycle();
    rstn = 1'b1;
  endtask

  task automatic window();
    bus.tx_ready = 1'b1;
    cycle();
    bus.tx_ready = 1'b0;
    cycle();
  endtask

  task automatic wait_fill(input string tag);
    int n;
    n = 0;
    bus.tx_ready = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      cycle();
      if (e_sent) begin n = k; break; end
    end
    check(tag, n, URT);
  endtask

  initial begin
    rstn = 1'b0;
    cfg_enable = '0; cfg_rr = 1'b1; cfg_mute = 1'b0; cfg_hold_last = 1'b0;
    bus.tx_ready = 1'b0;
    bus.src_valid = '0;
    bus.src_data = '0;
    for (int i = 0; i < N; i++) sdata[i] = '0;
    model_reset();
    #1;
    repeat (3) cycle();
    check("reset_sent", bus.tx_sent, 0);
    check("reset_ucnt", underrun_cnt, 0);
    rstn = 1'b1;
    cycle();

    // single source
    cfg_enable = 4'b0001;
    set_src(0, 1, 24'hAAAAAA);
    cycle();
    bus.tx_ready = 1'b1;
    cycle();
    check("single_sent", bus.tx_sent, 1);
    check("single_pcm", bus.tx_pcm, 24'hAAAAAA);
    check("single_ack", bus.src_ack, 4'b0001);
    check("single_gid", grant_id, 0);
    bus.tx_ready = 1'b0;
    set_src(0, 0, 24'hAAAAAA);
    cycle();

    // round-robin then fixed priority
    do_reset();
    cfg_enable = 4'b1111;
    for (int i = 0; i < N; i++) set_src(i, 1, DW'(i + 1));
    for (int w = 0; w < 8; w++) begin
      bus.tx_ready = 1'b1;
      cycle();
      check("rr_gid", grant_id, w % 4);
      check("rr_pcm", bus.tx_pcm, (w % 4) + 1);
      bus.tx_ready = 1'b0;
      cycle();
    end
    cfg_rr = 1'b0;
    for (int w = 0; w < 8; w++) begin
      bus.tx_ready = 1'b1;
      cycle();
      check("fixed_gid", grant_id, 0);
      bus.tx_ready = 1'b0;
      cycle();
    end
    cfg_rr = 1'b1;

    // underrun fill with hold_last, then zero fill
    do_reset();
    for (int i = 0; i < N; i++) set_src(i, 0, '0);
    cfg_enable = 4'b0001;
    set_src(0, 1, 24'h696969);
    window();
    check("prior_pcm", bus.tx_pcm, 24'h696969);
    set_src(0, 0, 24'h696969);
    cfg_hold_last = 1'b1;
    wait_fill("fill_latency_hold");
    check("fill_hold_pcm", bus.tx_pcm, 24'h696969);
    check("fill_hold_flag", fill_flag, 1);
    check("fill_hold_cnt", underrun_cnt, 1);
    bus.tx_ready = 1'b0;
    cycle();
    cfg_hold_last = 1'b0;
    wait_fill("fill_latency_zero");
    check("fill_zero_pcm", bus.tx_pcm, 0);
    check("fill_zero_cnt", underrun_cnt, 2);
    bus.tx_ready = 1'b0;
    cycle();

    // race: request lands when the dry counter is at its last value
    bus.tx_ready = 1'b1;
    repeat (URT - 1) cycle();
    cfg_enable = 4'b1111;
    set_src(1, 1, 24'hBEEF01);
    cycle();
    check("race_sent", bus.tx_sent, 1);
    check("race_fill", fill_flag, 0);
    check("race_ack", bus.src_ack, 4'b0010);
    check("race_cnt", underrun_cnt, 2);
    set_src(1, 0, 24'hBEEF01);
    bus.tx_ready = 1'b0;
    cycle();

    // mute, then disabled source produces a fill
    cfg_mute = 1'b1;
    set_src(2, 1, 24'h555555);
    bus.tx_ready = 1'b1;
    cycle();
    check("mute_pcm", bus.tx_pcm, 0);
    check("mute_ack", bus.src_ack, 4'b0100);
    bus.tx_ready = 1'b0;
    cycle();
    cfg_mute = 1'b0;
    cfg_enable = 4'b1011;
    set_src(2, 1, 24'h123456);
    ack2_cnt = 0;
    wait_fill("disabled_fill_latency");
    check("disabled_fill_flag", fill_flag, 1);
    check("src2_never_acked", ack2_cnt, 0);
    bus.tx_ready = 1'b0;
    cycle();

    // one strobe per long ready window, then reset during a strobe
    cfg_enable = 4'b1111;
    for (int i = 0; i < N; i++) set_src(i, 1, DW'(24'h100 + i));
    strobes = 0;
    bus.tx_ready = 1'b1;
    repeat (500) cycle();
    check("one_per_window", strobes, 1);
    bus.tx_ready = 1'b0;
    cycle();
    bus.tx_ready = 1'b1;
    cycle();
    check("pre_reset_sent", bus.tx_sent, 1);
    rstn = 1'b0;
    #1;
    check("rst_sent", bus.tx_sent, 0);
    check("rst_ack", bus.src_ack, 0);
    check("rst_pcm", bus.tx_pcm, 0);
    check("rst_gid", grant_id, 0);
    check("rst_fill", fill_flag, 0);
    check("rst_ucnt", underrun_cnt, 0);
    bus.tx_ready = 1'b0;
    cycle();
    cycle();
    rstn = 1'b1;
    bus.tx_ready = 1'b1;
    cycle();
    check("post_reset_ack", bus.src_ack, 4'b0001);
    bus.tx_ready = 1'b0;
    cycle();

    // randomized traffic
    for (int i = 0; i < N; i++) set_src(i, 0, '0);
    for (int t = 0; t < 4000; t++) begin
      rstn = 1'b1;
      if ($urandom_range(0, 29) == 0) bus.tx_ready = ~bus.tx_ready;
      if ($urandom_range(0, 199) == 0) cfg_enable = N'($urandom);
      if ($urandom_range(0, 149) == 0) cfg_rr = ~cfg_rr;
      if ($urandom_range(0, 149) == 0) cfg_mute = ~cfg_mute;
      if ($urandom_range(0, 99) == 0) cfg_hold_last = ~cfg_hold_last;
      if ($urandom_range(0, 1499) == 0) rstn = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (e_ack[i]) begin
          if ($urandom_range(0, 1) == 0) set_src(i, 0, sdata[i]);
          else set_src(i, 1, DW'($urandom));
        end else if (!bus.src_valid[i] && $urandom_range(0, 59) == 0) begin
          set_src(i, 1, DW'($urandom));
        end
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2s_tx_scheduler.md
# i2s_tx_scheduler

Sample scheduler that sits in the `clk` domain directly in front of the I2S transmitter's 24-bit `pcm_in` / `sent` / `ready` load port. It arbitrates among NUM_SRC audio sources with round-robin or fixed priority, and delivers exactly one sample per transmitter `ready` window. When no source has a sample ready in time, it substitutes a fill sample and counts the underrun. Mute and per-source enable are applied at arbitration time.

## Interface
- NUM_SRC, 4: number of requesting sources (2..8)
- DATA_W, 24: sample width; matches transmitter `pcm_in`
- UR_TIMEOUT, 64: `clk` cycles of `tx_ready`=1 with no eligible request before a fill sample is sent (>=2)
- clk  in  1  system clock; the transmitter load-side clock
- rstn  in  1  asynchronous, active-low reset
- src_valid  in  NUM_SRC  per-source sample available; held until matching `src_ack`
- src_data  in  NUM_SRC*DATA_W  source i occupies bits [i*DATA_W +: DATA_W]
- src_ack  out  NUM_SRC  one-cycle, one-hot: sample of source i consumed
- cfg_enable  in  NUM_SRC  source i eligible only when bit set
- cfg_rr  in  1  1 = round-robin, 0 = fixed priority (lowest index wins)
- cfg_mute  in  1  transmitted value forced to 0; the source is still acked
- cfg_hold_last  in  1  fill value: 1 = last `tx_pcm`, 0 = all zeros
- tx_ready  in  1  transmitter can accept a sample (level)
- tx_pcm  out  DATA_W  sample to transmitter; stable between `tx_sent` strobes
- tx_sent  out  1  one-cycle load strobe to transmitter
- grant_id  out  clog2(NUM_SRC)  index of last real grant
- fill_flag  out  1  1 = last strobe carried a fill sample
- underrun_cnt  out  16  saturating fill counter

## Operation
- States: IDLE, WAIT_DROP.
- IDLE:
  - Eligible set = `src_valid & cfg_enable`.
  - If `tx_ready`=1 and the eligible set is non-empty, the winner g is chosen combinationally.
  - On the next edge: `tx_pcm` <= (cfg_mute ? 0 : data[g]), `tx_sent`<=1, `src_ack[g]`<=1, `grant_id`<=g, `fill_flag`<=0; go to WAIT_DROP.
- Round-robin: search starts at rr_ptr+1 and wraps modulo NUM_SRC. rr_ptr <= g on real grants only.
- Fixed priority: lowest eligible index wins; rr_ptr is still updated.
- Underrun counter (uc):
  - In IDLE with `tx_ready`=1 and no eligible source, uc increments.
  - When uc = UR_TIMEOUT-1 and still no eligible source: `tx_pcm` <= (cfg_hold_last ? `tx_pcm` : 0), `tx_sent`<=1, `fill_flag`<=1, `underrun_cnt`++ (saturates at 16'hFFFF); go to WAIT_DROP. No ack is issued and rr_ptr is unchanged.
  - uc clears whenever `tx_ready`=0, a strobe is issued, or the state is not IDLE.
  - An eligible request arriving at the same edge uc reaches UR_TIMEOUT-1 wins; no fill is sent.
- Mute applies to real grants only. A fill while muted is 0 regardless of cfg_hold_last.
- WAIT_DROP:
  - `tx_sent`, `src_ack` return to 0.
  - Go to IDLE when `tx_ready`=0.
  - No arbitration in this state; this guarantees one sample per ready window.
- cfg_* are sampled each cycle and take effect at the next decision. Disabling a source whose valid is pending leaves it unacked.

## Timing
- Reset (async): `tx_pcm`=0, `tx_sent`=0, `src_ack`=0, `grant_id`=0, `fill_flag`=0, `underrun_cnt`=0, uc=0, rr_ptr=NUM_SRC-1 (src0 wins first), state IDLE.
- Reset mid-strobe drops `tx_sent` immediately. No partial ack survives.
- Latency: `tx_ready` rising with a valid source present -> `tx_sent` high 1 cycle later (first edge where IDLE sees both).
- All outputs are registered. `src_ack` and `tx_sent` are coincident and last exactly 1 cycle.
- Source contract:
  - Data is captured on the edge that raises `src_ack`.
  - The source may change valid/data from the edge after `src_ack` is seen high.
  - The earliest next grant to the same source is 2 cycles after its ack.
- `tx_ready` held high forever after a strobe: the block stays in WAIT_DROP and sends nothing further.
- Fill timing: the fill strobe occurs UR_TIMEOUT cycles after the first IDLE cycle with `tx_ready`=1 and no eligible source.

## Test plan
- Single source: cfg_enable=4'b0001, src0 valid with 24'hAAAAAA, then pulse `tx_ready` -> `tx_sent` 1 cycle after ready; `tx_pcm`=24'hAAAAAA; `src_ack`=4'b0001 coincident; `grant_id`=0.
- Round-robin: all 4 sources always valid (data 24'h000001..24'h000004), cfg_rr=1, 8 ready windows -> `grant_id` sequence 0,1,2,3,0,1,2,3. With cfg_rr=0 -> all eight grants go to 0.
- Underrun: no valid sources, `tx_ready`=1 -> fill strobe 64 cycles later, `fill_flag`=1, `underrun_cnt`=1. With cfg_hold_last=1 after a prior 24'h696969 -> `tx_pcm`=24'h696969; with cfg_hold_last=0 -> 24'h000000.
- Race: src1 valid asserted on the cycle uc=63 -> real grant of src1, no fill, `underrun_cnt` unchanged.
- Mute and enable: cfg_mute=1, src2 valid with 24'h555555 -> `tx_pcm`=0 and `src_ack`=4'b0100. cfg_enable[2]=0 -> src2 never acked and an underrun fill follows.
- One-per-window and reset: hold `tx_ready`=1 for 500 cycles with sources valid -> exactly one strobe. Assert rstn low during `tx_sent` -> all outputs 0 immediately; next grant goes to src0.
